// File: rtl/sdpram_rd_arbiter_pkg.sv
// Shared types, widths and reset constants for the SDP RAM read-port arbiter.
package sdpram_arb_pkg;

  localparam int LOCK_MAX_DEF = 4;

  localparam logic RST_LOCK_ACTIVE = 1'b0;
  localparam logic RST_RSP_BIT     = 1'b0;

  function automatic int req_id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // The counter never holds LOCK_MAX itself; reaching it releases the lock.
  function automatic int lock_cnt_width(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  typedef logic [lock_cnt_width(LOCK_MAX_DEF)-1:0] lock_cnt_t;

endpackage

// File: rtl/sdpram_rd_arbiter_if.sv
// Requester-side bus of the read arbiter: requests in, grants and tagged responses out.
interface sdpram_rd_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int WORD_DEPTH = 2
);
  import sdpram_arb_pkg::*;

  localparam int ID_W = req_id_width(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*WORD_DEPTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_addr, req_lock,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_lock,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/sdpram_rd_arbiter_pick.sv
// Round-robin picker: rotate requests to start at i_ptr, take the lowest set bit, map back.
module rr_prio_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0]    w_rot;
  logic [ID_W-1:0] w_pos;

  // i_ptr is always < N, so a single conditional subtract is enough to wrap.
  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  always_comb begin
    w_rot = '0;
    for (int k = 0; k < N; k++) begin
      w_rot[k] = i_req[wrap(int'(i_ptr) + k)];
    end
    w_pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_pos = ID_W'(k);
    end
    o_any = |i_req;
    o_idx = ID_W'(wrap(int'(i_ptr) + int'(w_pos)));
    o_gnt = o_any ? (ONE << o_idx) : '0;
  end

endmodule

// File: rtl/sdpram_rd_arbiter.sv
// Round-robin read-port arbiter for a simple dual-port RAM with bounded grant locking.
// Optional SDPRAM_RD_ARB_HOLD_EN keeps rsp_data at the last response through idle cycles.
module sdpram_rd_arbiter
  import sdpram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int WORD_DEPTH = 2,
  parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  sdpram_rd_arbiter_if.slave    bus,
  output logic                  ram_enb,
  output logic [WORD_DEPTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  localparam int ID_W  = req_id_width(NUM_REQ);
  localparam int CNT_W = lock_cnt_width(LOCK_MAX);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [ID_W-1:0]    r_rr_ptr, r_lock_owner, r_rsp_id;
  logic               r_lock_active;
  logic [CNT_W-1:0]   r_lock_cnt;
  logic [NUM_REQ-1:0] r_rsp_valid;

  logic [NUM_REQ-1:0] w_elig, w_gnt;
  logic [ID_W-1:0]    w_idx, w_ptr_nxt;
  logic               w_any, w_fire, w_lock_take, w_lock_expire;

  // A held lock narrows eligibility to the owner; nobody else fills its idle cycles.
  assign w_elig = r_lock_active ? (bus.req_valid & (ONE << r_lock_owner)) : bus.req_valid;

  rr_prio_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .i_req (w_elig),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_fire        = w_any & ~reset;
  assign bus.req_ready = w_fire ? w_gnt : '0;
  assign ram_enb       = w_fire;
  assign ram_addrb     = w_fire ? bus.req_addr[int'(w_idx)*WORD_DEPTH +: WORD_DEPTH] : '0;

  assign w_lock_take   = bus.req_lock[w_idx];
  assign w_lock_expire = (int'(r_lock_cnt) + 1 >= LOCK_MAX);

  always_comb begin
    w_ptr_nxt = '0;
    if (int'(w_idx) + 1 < NUM_REQ) w_ptr_nxt = w_idx + 1'b1;
  end

  // Grant registered alongside the RAM's own output register: one-cycle response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid   <= {NUM_REQ{RST_RSP_BIT}};
      r_rsp_id      <= '0;
      r_rr_ptr      <= '0;
      r_lock_active <= RST_LOCK_ACTIVE;
      r_lock_owner  <= '0;
      r_lock_cnt    <= '0;
    end else begin
      r_rsp_valid <= w_fire ? w_gnt : '0;
      if (w_fire) begin
        r_rsp_id <= w_idx;
        r_rr_ptr <= w_ptr_nxt;
        if (w_lock_take && !w_lock_expire) begin
          r_lock_active <= 1'b1;
          r_lock_owner  <= w_idx;
          r_lock_cnt    <= r_lock_cnt + 1'b1;
        end else begin
          r_lock_active <= 1'b0;
          r_lock_cnt    <= '0;
        end
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;

`ifdef SDPRAM_RD_ARB_HOLD_EN
  logic [DATA_WIDTH-1:0] r_rsp_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_hold <= '0;
    end else if (|r_rsp_valid) begin
      r_rsp_hold <= ram_doutb;
    end
  end

  assign bus.rsp_data = (|r_rsp_valid) ? ram_doutb : r_rsp_hold;
`else
  assign bus.rsp_data = ram_doutb;
`endif

endmodule

// File: tb/tb_sdpram_rd_arbiter.sv
// Scoreboard bench for sdpram_rd_arbiter with a behavioural RAM and arbitration model.
module tb_sdpram_rd_arbiter;
  import sdpram_arb_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 2;
  localparam int LM  = 4;
  localparam int IDW = req_id_width(N);
`ifdef SDPRAM_RD_ARB_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct {
    logic [N-1:0]   vld;
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    int             due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_doutb;
  logic          ram_we = 1'b0;
  logic [AW-1:0] ram_wa = '0;
  logic [DW-1:0] ram_wd = '0;
  logic [DW-1:0] ram_mem [2**AW];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] last_data = '0;
  logic [DW-1:0] ref_mem [2**AW];
  int            m_ptr = 0, m_owner = 0, m_cnt = 0;
  bit            m_lock = 1'b0;

  sdpram_rd_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .WORD_DEPTH(AW)) bus ();

  sdpram_rd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .WORD_DEPTH(AW), .LOCK_MAX(LM)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: registered read port returning old data on collision, 0 when not enabled.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_wa] <= ram_wd;
    ram_doutb <= ram_enb ? ram_mem[ram_addrb] : '0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Winner by the arbitration rules: owner only while locked, else first valid from the pointer.
  function automatic int ref_pick(input logic [N-1:0] v);
    int i;
    if (m_lock) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_cycle();
    int            g;
    logic [N-1:0]  oh;
    logic [AW-1:0] a;
    exp_t          e;
    g  = reset ? -1 : ref_pick(bus.req_valid);
    oh = '0;
    a  = '0;
    if (g >= 0) begin
      oh = N'(1) << g;
      a  = bus.req_addr[g*AW +: AW];
    end
    chk("req_ready", 64'(bus.req_ready), 64'(oh));
    chk("ram_enb", 64'(ram_enb), 64'(g >= 0));
    chk("ram_addrb", 64'(ram_addrb), 64'(a));
    if (g >= 0) begin
      e.vld  = oh;
      e.id   = IDW'(g);
      e.data = ref_mem[a];
      e.due  = cyc + 1;
      sb.push_back(e);
      m_ptr = (g + 1) % N;
      if (bus.req_lock[g]) begin
        m_cnt++;
        if (m_cnt == LM) begin
          m_lock = 1'b0;
          m_cnt  = 0;
        end else begin
          m_lock  = 1'b1;
          m_owner = g;
        end
      end else begin
        m_lock = 1'b0;
        m_cnt  = 0;
      end
    end
    if (reset) begin
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_lock = 1'b0;
    end
    if (ram_we) ref_mem[ram_wa] = ram_wd;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] lk, input logic [N*AW-1:0] ad,
                       input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic r);
    @(posedge clk);
    #1;
    bus.req_valid = v; bus.req_lock = lk; bus.req_addr = ad;
    ram_we = w; ram_wa = wa; ram_wd = wd; reset = r;
    @(negedge clk);
    model_cycle();
  endtask

  // Response monitor: an entry is due exactly one cycle after its grant.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(mon_e.vld));
        chk("rsp_id", 64'(bus.rsp_id), 64'(mon_e.id));
        chk("rsp_data", 64'(bus.rsp_data), 64'(mon_e.data));
        last_data = mon_e.data;
      end else begin
        chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'(0));
        chk("rsp_data_idle", 64'(bus.rsp_data), HOLD ? 64'(last_data) : 64'(0));
      end
      if (reset) last_data = '0;
    end
  end

  logic [N-1:0] lock_seq [8];
  logic [N-1:0] drop_seq [5];
  logic [N-1:0] drop_v   [5];
  logic [N-1:0] drop_l   [5];

  initial begin
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
    bus.req_valid = '1; bus.req_lock = '0; bus.req_addr = 8'hE4;
    lock_seq = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    drop_seq = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0100};
    drop_v   = '{4'b1111, 4'b1111, 4'b1011, 4'b1011, 4'b1111};
    drop_l   = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};

    // Reset two cycles with all requesters valid; preload mem[i] = 0xA0+i through the write port.
    drive(4'b1111, 4'b0000, 8'hE4, 1'b1, 2'd0, 32'hA0, 1'b1);
    drive(4'b1111, 4'b0000, 8'hE4, 1'b1, 2'd1, 32'hA1, 1'b1);
    drive(4'b1111, 4'b0000, 8'hE4, 1'b1, 2'd2, 32'hA2, 1'b0);
    chk("first_grant", 64'(bus.req_ready), 64'(4'b0001));
    drive(4'b1111, 4'b0000, 8'hE4, 1'b1, 2'd3, 32'hA3, 1'b0);
    for (int i = 0; i < 6; i++) drive(4'b1111, 4'b0000, 8'hE4, 1'b0, 2'd0, 32'h0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 4'b0010, 8'hE4, 1'b0, 2'd0, 32'h0, 1'b0);
      chk("lock_seq", 64'(bus.req_ready), 64'(lock_seq[i]));
    end

    for (int i = 0; i < 5; i++) begin
      drive(drop_v[i], drop_l[i], 8'hE4, 1'b0, 2'd0, 32'h0, 1'b0);
      chk("lock_drop", 64'(bus.req_ready), 64'(drop_seq[i]));
    end

    // Same-cycle write and read of addr 3: old data first, new data on the next read.
    drive(4'b0000, 4'b0000, 8'h00, 1'b1, 2'd3, 32'h11, 1'b0);
    drive(4'b0001, 4'b0000, 8'h03, 1'b1, 2'd3, 32'h55, 1'b0);
    drive(4'b0001, 4'b0000, 8'h03, 1'b0, 2'd0, 32'h0, 1'b0);
    chk("collision_old", 64'(bus.rsp_data), 64'(32'h11));
    drive(4'b0000, 4'b0000, 8'h00, 1'b0, 2'd0, 32'h0, 1'b0);
    chk("collision_new", 64'(bus.rsp_data), 64'(32'h55));
    drive(4'b0000, 4'b0000, 8'h00, 1'b0, 2'd0, 32'h0, 1'b0);
    chk("idle_data", 64'(bus.rsp_data), HOLD ? 64'(32'h55) : 64'(0));

    // Grant immediately followed by reset: the response still shows, then is gone.
    drive(4'b1111, 4'b0000, 8'hE4, 1'b0, 2'd0, 32'h0, 1'b0);
    drive(4'b1111, 4'b0000, 8'hE4, 1'b0, 2'd0, 32'h0, 1'b1);
    drive(4'b0000, 4'b0000, 8'hE4, 1'b0, 2'd0, 32'h0, 1'b0);

    for (int i = 0; i < 500; i++) begin
      drive(N'($urandom), N'($urandom & $urandom), (N*AW)'($urandom), 1'($urandom),
            AW'($urandom), $urandom, ($urandom_range(0, 59) == 0));
    end

    for (int i = 0; i < 3; i++) drive(4'b0000, 4'b0000, 8'h00, 1'b0, 2'd0, 32'h0, 1'b0);
    chk("sb_drain", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
